clk_1_result_rx: RTL and testbench
==================================

# clk_1_result_rx

Receives the computed CRC result coming back from the clk2 processing domain into the clk_1 domain and presents it as a one-cycle `out_valid`/`out` pulse. A toggle-level flag and a held result bus cross the domain boundary. This block synchronizes the toggle, captures the bus, and returns a toggle acknowledge so the clk2 side may release its data. It also tracks the single outstanding request issued by the clk_1 input side, and flags protocol errors and timeouts.

## Interface
- DATA_W, 60: result width (message plus CRC, or check result)
- TIMEOUT_CYC, 1023: maximum clk_1 cycles in WAIT before a timeout error
- SYNC_STAGES, 2: synchronizer depth on `clk2_flag`; 2 or 3 only
- clk_1  in  1  result-domain clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  request issued this cycle; same pulse that drives the clk_1 input capture
- clk2_flag  in  1  toggle level from clk2; one transition per result
- clk2_out  in  DATA_W  result bus; stable from the `clk2_flag` transition until `clk1_ack` has been seen by clk2
- out_valid  out  1  result valid, one-cycle pulse
- out  out  DATA_W  result; 0 whenever `out_valid`=0
- clk1_ack  out  1  toggle level back to clk2; one transition per detected result
- busy  out  1  request outstanding (state WAIT)
- err  out  2  sticky flags: [0] protocol, [1] timeout

## Operation
- Reset values: out_valid=0, out=0, clk1_ack=0, busy=0, err=2'b00. All synchronizer flops and the edge register are 0. State is IDLE. Timeout counter is 0.
- Edge detect: `res_pulse` = last synchronizer stage XOR the edge register. It is high for exactly one clk_1 cycle per `clk2_flag` transition.
- FSM states: IDLE, WAIT, OUT.
  - IDLE: in_valid → WAIT; counter cleared.
  - WAIT: busy=1; counter increments each cycle.
  - WAIT, res_pulse → OUT. On that edge: out ← clk2_out, out_valid ← 1.
  - WAIT, counter reaches TIMEOUT_CYC-1 with no res_pulse → IDLE, err[1] ← 1.
  - WAIT, res_pulse on the same cycle as the timeout → the result wins; go to OUT, no timeout error.
  - OUT: out_valid=1 for this one cycle. Next state is IDLE, or WAIT if in_valid is high in this cycle (back-to-back request accepted).
- clk1_ack toggles on every res_pulse, in any state, so the clk2 handshake never stalls.
- res_pulse in IDLE or OUT: result dropped, no out_valid, err[0] ← 1.
- in_valid in WAIT: ignored, err[0] ← 1, counter not restarted.
- Error bits are cleared only by rst_n.
- Counter width is $clog2(TIMEOUT_CYC)+1; it saturates and never wraps.

## Timing
- Let E0 be the first clk_1 edge that samples a new `clk2_flag` level.
  - SYNC_STAGES=2: res_pulse is high in the cycle after E1. out_valid, out and the clk1_ack toggle are all visible after E2.
  - SYNC_STAGES=3: everything is one cycle later.
- out_valid is never high on two consecutive cycles.
- Minimum spacing between results: clk2 must not toggle again until it has synchronized `clk1_ack`. This block does not check that rule.
- clk2_out is sampled only on the capture edge. No other path from clk2_out is allowed, since it is not synchronized.
- Asynchronous reset mid-transfer: outputs go to reset values immediately. A toggle pending in the synchronizer is discarded. clk2 must also be reset, because ack parity is lost.

## Structure
- Shared package/header: DATA_W default, FSM state encoding (IDLE=2'd0, WAIT=2'd1, OUT=2'd2), and the err bit index constants.
- Sub-module `toggle_sync`: parameterized SYNC_STAGES flop chain plus edge register, producing `res_pulse`. It will be reused for the clk2-side ack path.
- clk1_ack is driven by the existing `toggleff` instance, with d=res_pulse.

## Test plan
- Single transfer: in_valid at cycle 0; clk2_out=60'h0FEDCBA98765432 with clk2_flag 0→1 before edge 10 → busy=1 on cycles 1–11; out_valid=1, out=60'h0FEDCBA98765432 for one cycle after edge 12; clk1_ack=1; err=0.
- Back-to-back: second in_valid during the OUT cycle, second toggle 1→0 with data 60'h1 → two separate out_valid pulses with correct data; err=0.
- Timeout: TIMEOUT_CYC=8, in_valid, no toggle → busy for 8 cycles, then IDLE with err=2'b10 and out_valid never asserted. A later toggle → err=2'b11 and clk1_ack toggles.
- Spurious result: toggle with no request → no out_valid, err[0]=1, clk1_ack toggles; in_valid during WAIT also sets err[0].
- Reset mid-WAIT: pull rst_n low two cycles after in_valid → all outputs 0 asynchronously. After release, a new request/toggle pair completes normally.
- Random clk2 phase, clk_1 to clk2 period ratio swept 1:3 to 3:1, 1000 transfers → every result delivered exactly once, in order, with no err.

Source files
------------

// File: rtl/clk_1_result_rx_pkg.sv
// Shared types and constants for the clk2 -> clk_1 result receiver.
package clk_1_result_rx_pkg;

  localparam int DATA_W_DEF = 60;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam int ERR_PROTO   = 0;
  localparam int ERR_TIMEOUT = 1;

  // One spare bit so the saturating counter can hold TIMEOUT_CYC itself.
  function automatic int cnt_width(input int timeout_cyc);
    return $clog2(timeout_cyc) + 1;
  endfunction

endpackage

// File: rtl/clk_1_result_rx_if.sv
// Request/result handshake bundle between the clk2 result path and clk_1 consumer.
interface clk_1_result_rx_if #(
  parameter int DATA_W = clk_1_result_rx_pkg::DATA_W_DEF
);
  logic              in_valid;
  logic              clk2_flag;
  logic [DATA_W-1:0] clk2_out;
  logic              out_valid;
  logic [DATA_W-1:0] out;
  logic              clk1_ack;
  logic              busy;
  logic [1:0]        err;

  modport master (
    output in_valid, clk2_flag, clk2_out,
    input  out_valid, out, clk1_ack, busy, err
  );

  modport slave (
    input  in_valid, clk2_flag, clk2_out,
    output out_valid, out, clk1_ack, busy, err
  );
endinterface

// File: rtl/clk_1_result_rx_toggle_sync.sv
// Synchronizes a toggle level into clk and emits a one-cycle pulse per transition.
// STAGES must be 2 or 3; the same block serves the clk2-side ack path.
module clk_1_result_rx_toggle_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tgl_in,
  output logic pulse
);
  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              edge_q;
  logic              edge_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], tgl_in};
    edge_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign pulse = sync_q[STAGES-1] ^ edge_q;
endmodule

// File: rtl/toggleff.sv
// Toggle flop: q inverts on every cycle where t is high.
module toggleff (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);
  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q ^ t;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/clk_1_result_rx.sv
// Receives the clk2 CRC result into clk_1: toggle sync, bus capture, toggle ack,
// single-outstanding-request tracking with sticky protocol/timeout errors.
module clk_1_result_rx
  import clk_1_result_rx_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 1023,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk_1,
  input logic              rst_n,
  clk_1_result_rx_if.slave bus
);
  localparam int                CNT_W    = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic [1:0]        err_q, err_d;
  logic              res_pulse;

  clk_1_result_rx_toggle_sync #(.STAGES(SYNC_STAGES)) u_toggle_sync (
    .clk    (clk_1),
    .rst_n  (rst_n),
    .tgl_in (bus.clk2_flag),
    .pulse  (res_pulse)
  );

  // Ack follows every detected transition regardless of state so clk2 never stalls.
  toggleff u_ack_tff (
    .clk   (clk_1),
    .rst_n (rst_n),
    .t     (res_pulse),
    .q     (bus.clk1_ack)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    out_d       = '0;
    out_valid_d = 1'b0;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) state_d = WAIT;
        if (res_pulse)    err_d[ERR_PROTO] = 1'b1;
      end
      WAIT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (bus.in_valid) err_d[ERR_PROTO] = 1'b1;
        // clk2_out is only ever sampled here, on the capture edge.
        if (res_pulse) begin
          state_d     = OUT;
          out_valid_d = 1'b1;
          out_d       = bus.clk2_out;
        end else if (cnt_q >= CNT_LAST) begin
          state_d            = IDLE;
          err_d[ERR_TIMEOUT] = 1'b1;
        end
      end
      OUT: begin
        state_d = bus.in_valid ? WAIT : IDLE;
        if (res_pulse) err_d[ERR_PROTO] = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.busy      = (state_q == WAIT);
  assign bus.err       = err_q;
endmodule

// File: tb/tb_clk_1_result_rx.sv
// Directed + random-phase bench for clk_1_result_rx with an in-order result scoreboard.
module tb_clk_1_result_rx;
  localparam int DW = 60;

  logic clk_1 = 1'b0;
  logic rst_n = 1'b0;
  always #6 clk_1 = ~clk_1;

  clk_1_result_rx_if #(.DATA_W(DW)) if_a ();
  clk_1_result_rx_if #(.DATA_W(DW)) if_b ();

  clk_1_result_rx #(.DATA_W(DW), .TIMEOUT_CYC(1023), .SYNC_STAGES(2)) u_a (
    .clk_1 (clk_1), .rst_n (rst_n), .bus (if_a.slave)
  );
  clk_1_result_rx #(.DATA_W(DW), .TIMEOUT_CYC(8), .SYNC_STAGES(3)) u_b (
    .clk_1 (clk_1), .rst_n (rst_n), .bus (if_b.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_push = 0;
  int n_deliv = 0;
  logic [DW-1:0] exp_q[$];
  logic prev_vld = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk_1);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    exp_q.push_back(d);
    n_push++;
  endtask

  task automatic wait_out_a(input string tag);
    int k;
    k = 0;
    while (if_a.out_valid !== 1'b1 && k < 30) begin
      cyc();
      k++;
    end
    chk(tag, 64'(k < 30), 64'(1));
  endtask

  // Scoreboard consumer on the main instance.
  logic [DW-1:0] exp_d;
  always @(negedge clk_1) begin
    if (if_a.out_valid === 1'b1) begin
      chk("no_back_to_back", 64'(prev_vld), 64'(0));
      chk("expected_pending", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        exp_d = exp_q.pop_front();
        chk("out_data", 64'(if_a.out), 64'(exp_d));
        n_deliv++;
      end
    end else if (prev_vld) begin
      chk("out_zero_after_pulse", 64'(if_a.out), 64'(0));
    end
    prev_vld = (if_a.out_valid === 1'b1);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, vb, p2, k;
    logic [DW-1:0] d;

    if_a.in_valid = 0; if_a.clk2_flag = 0; if_a.clk2_out = '0;
    if_b.in_valid = 0; if_b.clk2_flag = 0; if_b.clk2_out = '0;
    repeat (3) cyc();
    chk("rst_out_valid", 64'(if_a.out_valid), 64'(0));
    chk("rst_out", 64'(if_a.out), 64'(0));
    chk("rst_ack", 64'(if_a.clk1_ack), 64'(0));
    chk("rst_busy", 64'(if_a.busy), 64'(0));
    chk("rst_err", 64'(if_a.err), 64'(0));
    rst_n = 1;
    cyc();

    // Single transfer, then a back-to-back request issued in the OUT cycle.
    if_a.in_valid = 1; if_a.clk2_out = 60'h0FEDCBA98765432;
    cyc();
    if_a.in_valid = 0;
    chk("t1_busy_start", 64'(if_a.busy), 64'(1));
    repeat (9) cyc();
    if_a.clk2_flag = 1; push(60'h0FEDCBA98765432);
    cyc();
    cyc();
    chk("t1_busy_end", 64'(if_a.busy), 64'(1));
    chk("t1_no_early_vld", 64'(if_a.out_valid), 64'(0));
    cyc();
    chk("t1_vld", 64'(if_a.out_valid), 64'(1));
    chk("t1_out", 64'(if_a.out), 64'h0FEDCBA98765432);
    chk("t1_ack", 64'(if_a.clk1_ack), 64'(1));
    chk("t1_busy_out", 64'(if_a.busy), 64'(0));
    chk("t1_err", 64'(if_a.err), 64'(0));
    if_a.in_valid = 1;
    cyc();
    if_a.in_valid = 0;
    chk("t2_vld_low", 64'(if_a.out_valid), 64'(0));
    chk("t2_busy", 64'(if_a.busy), 64'(1));
    if_a.clk2_flag = 0; if_a.clk2_out = 60'h1; push(60'h1);
    repeat (3) cyc();
    chk("t2_vld", 64'(if_a.out_valid), 64'(1));
    chk("t2_out", 64'(if_a.out), 64'h1);
    chk("t2_ack", 64'(if_a.clk1_ack), 64'(0));
    chk("t2_err", 64'(if_a.err), 64'(0));
    cyc();
    chk("t2_idle", 64'(if_a.busy), 64'(0));

    // Spurious result with no request outstanding.
    if_a.clk2_flag = 1; if_a.clk2_out = 60'hABC;
    repeat (5) cyc();
    chk("spur_err", 64'(if_a.err), 64'b01);
    chk("spur_ack", 64'(if_a.clk1_ack), 64'(1));
    chk("spur_busy", 64'(if_a.busy), 64'(0));

    // Timeout on the short-timeout, 3-stage instance.
    if_b.in_valid = 1;
    cyc();
    if_b.in_valid = 0;
    nb = 0; vb = 0;
    for (int i = 0; i < 12; i++) begin
      nb += int'(if_b.busy);
      vb += int'(if_b.out_valid);
      cyc();
    end
    chk("to_busy_cycles", 64'(nb), 64'(8));
    chk("to_err", 64'(if_b.err), 64'b10);
    chk("to_no_vld", 64'(vb), 64'(0));
    if_b.clk2_flag = 1; if_b.clk2_out = 60'h77;
    vb = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      vb += int'(if_b.out_valid);
    end
    chk("to_late_err", 64'(if_b.err), 64'b11);
    chk("to_late_ack", 64'(if_b.clk1_ack), 64'(1));
    chk("to_late_no_vld", 64'(vb), 64'(0));

    // Asynchronous reset two cycles into WAIT; clk2 side is reset alongside.
    if_a.in_valid = 1;
    cyc();
    if_a.in_valid = 0;
    cyc();
    cyc();
    #2 rst_n = 0;
    #1;
    chk("arst_out_valid", 64'(if_a.out_valid), 64'(0));
    chk("arst_out", 64'(if_a.out), 64'(0));
    chk("arst_ack", 64'(if_a.clk1_ack), 64'(0));
    chk("arst_busy", 64'(if_a.busy), 64'(0));
    chk("arst_err", 64'(if_a.err), 64'(0));
    chk("arst_b_err", 64'(if_b.err), 64'(0));
    if_a.clk2_flag = 0; if_b.clk2_flag = 0;
    cyc();
    cyc();
    rst_n = 1;
    cyc();
    if_a.in_valid = 1; if_a.clk2_out = 60'h123456789ABCDEF;
    cyc();
    if_a.in_valid = 0;
    if_a.clk2_flag = 1; push(60'h123456789ABCDEF);
    wait_out_a("arst_recover_timeout");
    chk("arst_recover_err", 64'(if_a.err), 64'(0));
    chk("arst_recover_ack", 64'(if_a.clk1_ack), 64'(1));

    // Request while already waiting flags a protocol error but the result still lands.
    cyc();
    if_a.in_valid = 1;
    cyc();
    if_a.in_valid = 0;
    cyc();
    if_a.in_valid = 1;
    cyc();
    if_a.in_valid = 0;
    chk("wait_req_err", 64'(if_a.err), 64'b01);
    chk("wait_req_busy", 64'(if_a.busy), 64'(1));
    if_a.clk2_flag = 0; if_a.clk2_out = 60'h0F0F0F0F;
    push(60'h0F0F0F0F);
    wait_out_a("wait_req_timeout");
    cyc();
    chk("wait_req_idle", 64'(if_a.busy), 64'(0));

    rst_n = 0;
    cyc();
    rst_n = 1;
    cyc();

    // Random clk2 period and phase, clk2 waits for the ack before releasing data.
    for (int i = 0; i < 1000; i++) begin
      p2 = $urandom_range(4, 36);
      @(posedge clk_1); #1;
      if_a.in_valid = 1;
      @(posedge clk_1); #1;
      if_a.in_valid = 0;
      #($urandom_range(0, 3 * p2));
      d = DW'({$urandom(), $urandom()});
      if_a.clk2_out = d;
      if_a.clk2_flag = ~if_a.clk2_flag;
      push(d);
      k = 0;
      while (if_a.clk1_ack !== if_a.clk2_flag && k < 400) begin
        #(p2);
        k++;
      end
      if (k >= 400) chk("rand_ack_timeout", 64'(k), 64'(0));
      #(2 * p2);
      if_a.clk2_out = DW'({$urandom(), $urandom()});
    end
    repeat (4) cyc();
    chk("rand_all_delivered", 64'(n_deliv), 64'(n_push));
    chk("rand_queue_empty", 64'(exp_q.size()), 64'(0));
    chk("rand_err", 64'(if_a.err), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
